// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: one valid/ready stream of writeback entries.
//   valid   : producer has an entry this cycle
//   ready   : consumer accepts this cycle
//   rd_addr : destination register
//   rd      : result value
//   wb_en   : writeback enable
//   meta    : opaque sideband payload
// master = producer side, slave = consumer side.
interface pipe_stage_reg_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int META_W     = 8
);
  logic                  valid;
  logic                  ready;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [XLEN-1:0]       rd;
  logic                  wb_en;
  logic [META_W-1:0]     meta;

  modport master (output valid, rd_addr, rd, wb_en, meta, input  ready);
  modport slave  (input  valid, rd_addr, rd, wb_en, meta, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: 2-entry in-order skid buffer between pipeline stages,
// with a register-bypass lookup across both held entries.
//   clk, rst   : clock, synchronous active-low reset
//   flush      : synchronous kill of all held entries
//   in_if      : upstream stream (slave); in_if.ready is a registered flag
//   out_if     : downstream stream (master); fields are 0 when not valid
//   occupancy  : number of held entries, 0..2
//   fwd_addr   : bypass lookup address
//   fwd_hit    : a held entry will write fwd_addr (x0 never hits)
//   fwd_data   : youngest matching value, 0 when no hit
module pipe_stage_reg #(
  parameter int XLEN            = 32,
  parameter int REG_ADDR_W      = 5,
  parameter int META_W          = 8,
  parameter int ZERO_REG_SQUASH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  pipe_stage_reg_if.slave       in_if,
  pipe_stage_reg_if.master      out_if,
  output logic [1:0]            occupancy,
  input  logic [REG_ADDR_W-1:0] fwd_addr,
  output logic                  fwd_hit,
  output logic [XLEN-1:0]       fwd_data
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       rd;
    logic                  wb_en;
    logic [META_W-1:0]     meta;
  } entry_t;

  entry_t     head_q, skid_q, head_d, skid_d, in_ent;
  logic [1:0] occ_q, occ_d;
  logic       rdy_q;
  logic       acc, drn, head_vld, skid_vld;
  logic       head_hit, skid_hit;

  assign head_vld = (occ_q != 2'd0);
  assign skid_vld = (occ_q == 2'd2);

  // rdy_q tracks "room for one more"; the reset term only forces it low
  // while reset is asserted so the first post-reset cycle can accept.
  assign in_if.ready = rdy_q & rst;
  assign acc = in_if.valid & in_if.ready;
  assign drn = head_vld & out_if.ready;

  always_comb begin
    in_ent.rd_addr = in_if.rd_addr;
    in_ent.rd      = in_if.rd;
    in_ent.meta    = in_if.meta;
    in_ent.wb_en   = in_if.wb_en &
                     ~((ZERO_REG_SQUASH != 0) && (in_if.rd_addr == '0));
  end

  // Vacated slots are cleared so the head register doubles as the
  // zeroed bubble output without extra muxing.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    occ_d  = occ_q;
    case (occ_q)
      2'd0: if (acc) begin
        head_d = in_ent;
        occ_d  = 2'd1;
      end
      2'd1: begin
        if (acc && drn) begin
          head_d = in_ent;
        end else if (acc) begin
          skid_d = in_ent;
          occ_d  = 2'd2;
        end else if (drn) begin
          head_d = '0;
          occ_d  = 2'd0;
        end
      end
      2'd2: if (drn) begin
        // in_ready is low at occupancy 2, so no accept can coincide
        head_d = skid_q;
        skid_d = '0;
        occ_d  = 2'd1;
      end
      default: begin
        head_d = '0;
        skid_d = '0;
        occ_d  = 2'd0;
      end
    endcase
    if (flush) begin
      head_d = '0;
      skid_d = '0;
      occ_d  = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q <= '0;
      skid_q <= '0;
      occ_q  <= 2'd0;
      rdy_q  <= 1'b1;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
      occ_q  <= occ_d;
      rdy_q  <= (occ_d != 2'd2);
    end
  end

  assign occupancy      = occ_q;
  assign out_if.valid   = head_vld;
  assign out_if.rd_addr = head_q.rd_addr;
  assign out_if.rd      = head_q.rd;
  assign out_if.wb_en   = head_q.wb_en;
  assign out_if.meta    = head_q.meta;

  // Skid is younger than head, so it takes priority on a double match.
  assign head_hit = head_vld & head_q.wb_en & (head_q.rd_addr == fwd_addr);
  assign skid_hit = skid_vld & skid_q.wb_en & (skid_q.rd_addr == fwd_addr);
  assign fwd_hit  = (fwd_addr != '0) & (head_hit | skid_hit);

  always_comb begin
    fwd_data = '0;
    if (fwd_addr != '0) begin
      if (skid_hit)      fwd_data = skid_q.rd;
      else if (head_hit) fwd_data = head_q.rd;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int MW   = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic [1:0]      occupancy;
  logic [AW-1:0]   fwd_addr = '0;
  logic            fwd_hit;
  logic [XLEN-1:0] fwd_data;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.XLEN(XLEN), .REG_ADDR_W(AW), .META_W(MW)) in_if ();
  pipe_stage_reg_if #(.XLEN(XLEN), .REG_ADDR_W(AW), .META_W(MW)) out_if ();

  pipe_stage_reg #(.XLEN(XLEN), .REG_ADDR_W(AW), .META_W(MW), .ZERO_REG_SQUASH(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_if(in_if), .out_if(out_if),
    .occupancy(occupancy),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] rd;
    logic            wb;
    logic [MW-1:0]   meta;
  } ent_t;

  // Reference: a plain FIFO of at most two entries, oldest first.
  ent_t q[$];
  bit   rdy_model = 1'b0;
  bit   chk_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares everything the DUT shows this cycle, pops on drain.
  initial begin
    forever begin
      @(negedge clk);
      rdy_model = rst && (q.size() < 2);
      if (chk_en) begin
        ent_t e;
        bit hit;
        logic [XLEN-1:0] fd;
        e = (q.size() != 0) ? q[0] : '0;
        chk("in_ready", in_if.ready, rdy_model);
        chk("occupancy", occupancy, q.size());
        chk("out_valid", out_if.valid, q.size() != 0);
        chk("out_rd_addr", out_if.rd_addr, e.addr);
        chk("out_rd", out_if.rd, e.rd);
        chk("out_wb_en", out_if.wb_en, e.wb);
        chk("out_meta", out_if.meta, e.meta);
        hit = 1'b0;
        fd = '0;
        if (fwd_addr != 0) begin
          for (int i = q.size() - 1; i >= 0; i--) begin
            if (!hit && q[i].wb && q[i].addr == fwd_addr) begin
              hit = 1'b1;
              fd = q[i].rd;
            end
          end
        end
        chk("fwd_hit", fwd_hit, hit);
        chk("fwd_data", fwd_data, fd);
        if (q.size() != 0 && out_if.ready) void'(q.pop_front());
      end
    end
  end

  // Driver: applies one cycle of stimulus and pushes what should be accepted.
  task automatic cyc(input bit r, input bit fl, input bit iv, input logic [AW-1:0] a,
                     input logic [XLEN-1:0] d, input bit wb, input logic [MW-1:0] m,
                     input bit ordy, input logic [AW-1:0] fa);
    ent_t n;
    @(posedge clk);
    #1;
    rst = r; flush = fl;
    in_if.valid = iv; in_if.rd_addr = a; in_if.rd = d; in_if.wb_en = wb; in_if.meta = m;
    out_if.ready = ordy; fwd_addr = fa;
    @(negedge clk);
    #1;
    if (!r || fl) begin
      q.delete();
    end else if (iv && rdy_model) begin
      n.addr = a; n.rd = d; n.meta = m;
      n.wb = wb && (a != 0);
      q.push_back(n);
    end
    chk_en = 1'b1;
  endtask

  task automatic idle(input bit ordy, input logic [AW-1:0] fa);
    cyc(1, 0, 0, 0, 0, 0, 0, ordy, fa);
  endtask

  initial begin
    in_if.valid = 0; in_if.rd_addr = 0; in_if.rd = 0; in_if.wb_en = 0; in_if.meta = 0;
    out_if.ready = 0;
    // reset with live inputs that must be ignored
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 3, 32'h1234, 1, 8'h5, 1, 3);
    // single pass
    cyc(1, 0, 1, 5, 32'hDEADBEEF, 1, 8'h11, 1, 5);
    idle(1, 5);
    idle(1, 0);
    // backpressure: A, B fill; C rejected; drain A then B
    cyc(1, 0, 1, 1, 32'hA, 1, 8'hA0, 0, 1);
    cyc(1, 0, 1, 2, 32'hB, 1, 8'hB0, 0, 2);
    cyc(1, 0, 1, 3, 32'hC, 1, 8'hC0, 0, 2);
    idle(1, 1);
    idle(1, 2);
    idle(1, 0);
    // streaming
    for (int i = 0; i < 10; i++) cyc(1, 0, 1, 4, i, 1, i, 1, 4);
    idle(1, 0);
    // x0 squash
    cyc(1, 0, 1, 0, 32'h5, 1, 8'h22, 0, 0);
    idle(0, 0);
    idle(1, 0);
    // forwarding: both match, skid wins; then skid wb_en=0
    cyc(1, 0, 1, 7, 32'h10, 1, 0, 0, 7);
    cyc(1, 0, 1, 7, 32'h20, 1, 0, 0, 7);
    idle(0, 7);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 7);
    cyc(1, 0, 1, 7, 32'h10, 1, 0, 0, 7);
    cyc(1, 0, 1, 7, 32'h20, 0, 0, 0, 7);
    idle(0, 7);
    // flush at occupancy 2 with in_valid and out_ready high
    cyc(1, 1, 1, 9, 32'h99, 1, 0, 1, 9);
    idle(0, 9);
    // reset mid-stream at occupancy 2
    cyc(1, 0, 1, 9, 32'h91, 1, 0, 0, 9);
    cyc(1, 0, 1, 9, 32'h92, 1, 0, 0, 9);
    cyc(0, 0, 1, 9, 32'h93, 1, 0, 1, 9);
    cyc(0, 0, 1, 9, 32'h94, 1, 0, 1, 9);
    cyc(1, 0, 1, 9, 32'h95, 1, 0, 1, 9);
    idle(1, 9);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 19) == 0),
          $urandom_range(0, 1), $urandom_range(0, 7), $urandom, $urandom_range(0, 1),
          $urandom, ($urandom_range(0, 2) != 0), $urandom_range(0, 7));
    end
    idle(1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
